// File: rtl/store_align_split_if.sv
// Store request, data-memory bus beat and completion signals of the store align/split unit.
// The slave modport is the unit itself; master is the core/bus side driving it.
interface store_align_split_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
);
   localparam int unsigned NB = XLEN / 8;

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic [XLEN-1:0]   req_data;

   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic [NB-1:0]     mem_wstrb;

   logic              rsp_valid;
   logic              rsp_fault;
   logic              rsp_split;

   modport slave (
      input  req_valid, req_addr, req_size, req_data, mem_ready,
      output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output rsp_valid, rsp_fault, rsp_split
   );

   modport master (
      output req_valid, req_addr, req_size, req_data, mem_ready,
      input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  rsp_valid, rsp_fault, rsp_split
   );
endinterface

// File: rtl/store_align_split.sv
// Store alignment/split unit: positions store data and strobes on the bus word and issues one
// or two aligned beats, or reports a fault for illegal/disallowed misaligned stores.
module store_align_split #(
   parameter int unsigned XLEN             = 32,
   parameter int unsigned ADDR_W           = 32,
   parameter bit          ALLOW_MISALIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               resetn,
   store_align_split_if.slave bus
);
   localparam int unsigned NB  = XLEN / 8;
   localparam int unsigned OFS = $clog2(NB);

   typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

   state_e state_q, state_d;
   logic   load;

   logic [ADDR_W-1:0] b0_addr_q, b1_addr_q;
   logic [XLEN-1:0]   b0_data_q, b1_data_q;
   logic [NB-1:0]     b0_strb_q, b1_strb_q;
   logic              split_q, fault_q;

   logic [3:0]        nbytes;
   logic [2:0]        align_mask;
   logic [NB-1:0]     size_mask;
   logic [XLEN-1:0]   data_m;
   logic [OFS-1:0]    off;
   logic [2*XLEN-1:0] data_sh;
   logic [2*NB-1:0]   strb_sh;
   logic [ADDR_W-1:0] base;
   logic              illegal, misaligned, split, fault;

   // Request decode, evaluated every cycle and captured only on accept.
   always_comb begin
      nbytes     = 4'd1 << bus.req_size;
      align_mask = 3'(nbytes - 4'd1);
      size_mask  = '0;
      data_m     = '0;
      for (int i = 0; i < int'(NB); i++) begin
         size_mask[i]    = (i < int'(nbytes));
         data_m[8*i +: 8] = size_mask[i] ? bus.req_data[8*i +: 8] : 8'h00;
      end
   end

   assign off        = bus.req_addr[OFS-1:0];
   assign data_sh    = {{XLEN{1'b0}}, data_m} << {off, 3'b000};
   assign strb_sh    = {{NB{1'b0}}, size_mask} << off;
   assign base       = {bus.req_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
   assign illegal    = (XLEN == 32) && (bus.req_size == 2'd3);
   assign misaligned = |(bus.req_addr[2:0] & align_mask);
   assign split      = |strb_sh[2*NB-1:NB];
   assign fault      = illegal || (misaligned && !ALLOW_MISALIGNED);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               load    = 1'b1;
               state_d = fault ? StResp : StBeat0;
            end
         end
         StBeat0: begin
            if (bus.mem_ready) state_d = split_q ? StBeat1 : StResp;
         end
         StBeat1: begin
            if (bus.mem_ready) state_d = StResp;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         b0_addr_q <= '0;
         b0_data_q <= '0;
         b0_strb_q <= '0;
         b1_addr_q <= '0;
         b1_data_q <= '0;
         b1_strb_q <= '0;
         split_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else if (load) begin
         b0_addr_q <= base;
         b0_data_q <= data_sh[XLEN-1:0];
         b0_strb_q <= strb_sh[NB-1:0];
         b1_addr_q <= base + ADDR_W'(NB);
         b1_data_q <= data_sh[2*XLEN-1:XLEN];
         b1_strb_q <= strb_sh[2*NB-1:NB];
         split_q   <= split;
         fault_q   <= fault;
      end
   end

   // Bus outputs are zero outside beat states so reset and idle present a quiet bus.
   always_comb begin
      bus.req_ready = (state_q == StIdle);
      bus.mem_valid = (state_q == StBeat0) || (state_q == StBeat1);
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_wstrb = '0;
      if (state_q == StBeat0) begin
         bus.mem_addr  = b0_addr_q;
         bus.mem_wdata = b0_data_q;
         bus.mem_wstrb = b0_strb_q;
      end else if (state_q == StBeat1) begin
         bus.mem_addr  = b1_addr_q;
         bus.mem_wdata = b1_data_q;
         bus.mem_wstrb = b1_strb_q;
      end
      bus.rsp_valid = (state_q == StResp);
      bus.rsp_fault = (state_q == StResp) && fault_q;
      bus.rsp_split = (state_q == StResp) && split_q;
   end
endmodule

// File: tb/tb_store_align_split.sv
// Directed bench for store_align_split: 32-bit split/no-split/fault configurations and 64-bit.
module tb_store_align_split;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   store_align_split_if #(.XLEN(32), .ADDR_W(32)) bus32 ();
   store_align_split_if #(.XLEN(32), .ADDR_W(32)) bus32n ();
   store_align_split_if #(.XLEN(64), .ADDR_W(32)) bus64 ();

   store_align_split #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut32 (
      .clk(clk), .resetn(resetn), .bus(bus32)
   );
   store_align_split #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut32n (
      .clk(clk), .resetn(resetn), .bus(bus32n)
   );
   store_align_split #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut64 (
      .clk(clk), .resetn(resetn), .bus(bus64)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send32(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
      @(negedge clk);
      bus32.mem_ready = 1'b0;
      check("req_ready idle", {63'd0, bus32.req_ready}, 64'd1);
      bus32.req_valid = 1'b1;
      bus32.req_addr  = addr;
      bus32.req_size  = size;
      bus32.req_data  = data;
      @(posedge clk);
   endtask

   task automatic beat32(input string tag, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input int waits);
      for (int w = 0; w <= waits; w++) begin
         @(negedge clk);
         bus32.req_valid = 1'b0;
         check({tag, " mem_valid"}, {63'd0, bus32.mem_valid}, 64'd1);
         check({tag, " mem_addr"}, {32'd0, bus32.mem_addr}, {32'd0, a});
         check({tag, " mem_wstrb"}, {60'd0, bus32.mem_wstrb}, {60'd0, s});
         check({tag, " mem_wdata"}, {32'd0, bus32.mem_wdata}, {32'd0, d});
         check({tag, " rsp_valid low"}, {63'd0, bus32.rsp_valid}, 64'd0);
         bus32.mem_ready = (w == waits);
      end
      @(posedge clk);
   endtask

   task automatic resp32(input string tag, input logic fault, input logic split);
      @(negedge clk);
      bus32.req_valid = 1'b0;
      bus32.mem_ready = 1'b0;
      check({tag, " rsp_valid"}, {63'd0, bus32.rsp_valid}, 64'd1);
      check({tag, " rsp_fault"}, {63'd0, bus32.rsp_fault}, {63'd0, fault});
      check({tag, " rsp_split"}, {63'd0, bus32.rsp_split}, {63'd0, split});
      check({tag, " mem_valid low"}, {63'd0, bus32.mem_valid}, 64'd0);
      check({tag, " req_ready busy"}, {63'd0, bus32.req_ready}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      check({tag, " rsp one cycle"}, {63'd0, bus32.rsp_valid}, 64'd0);
      check({tag, " ready again"}, {63'd0, bus32.req_ready}, 64'd1);
   endtask

   // Single-beat store on the 64-bit unit, zero-wait bus.
   task automatic one64(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic [63:0] data, input logic [31:0] ea, input logic [7:0] es,
                        input logic [63:0] ed);
      @(negedge clk);
      bus64.req_valid = 1'b1;
      bus64.req_addr  = addr;
      bus64.req_size  = size;
      bus64.req_data  = data;
      @(posedge clk);
      @(negedge clk);
      bus64.req_valid = 1'b0;
      check({tag, " mem_valid"}, {63'd0, bus64.mem_valid}, 64'd1);
      check({tag, " mem_addr"}, {32'd0, bus64.mem_addr}, {32'd0, ea});
      check({tag, " mem_wstrb"}, {56'd0, bus64.mem_wstrb}, {56'd0, es});
      check({tag, " mem_wdata"}, bus64.mem_wdata, ed);
      bus64.mem_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus64.mem_ready = 1'b0;
      check({tag, " rsp_valid"}, {63'd0, bus64.rsp_valid}, 64'd1);
      check({tag, " rsp_split"}, {63'd0, bus64.rsp_split}, 64'd0);
      check({tag, " rsp_fault"}, {63'd0, bus64.rsp_fault}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus32.req_valid = 1'b0; bus32.req_addr = '0; bus32.req_size = '0; bus32.req_data = '0;
      bus32.mem_ready = 1'b0;
      bus32n.req_valid = 1'b0; bus32n.req_addr = '0; bus32n.req_size = '0;
      bus32n.req_data = '0; bus32n.mem_ready = 1'b0;
      bus64.req_valid = 1'b0; bus64.req_addr = '0; bus64.req_size = '0; bus64.req_data = '0;
      bus64.mem_ready = 1'b0;

      // Reset state
      #12;
      check("rst req_ready", {63'd0, bus32.req_ready}, 64'd1);
      check("rst mem_valid", {63'd0, bus32.mem_valid}, 64'd0);
      check("rst rsp_valid", {63'd0, bus32.rsp_valid}, 64'd0);
      check("rst rsp_fault", {63'd0, bus32.rsp_fault}, 64'd0);
      check("rst rsp_split", {63'd0, bus32.rsp_split}, 64'd0);
      check("rst mem_addr", {32'd0, bus32.mem_addr}, 64'd0);
      check("rst mem_wdata", {32'd0, bus32.mem_wdata}, 64'd0);
      check("rst mem_wstrb", {60'd0, bus32.mem_wstrb}, 64'd0);
      @(negedge clk);
      resetn = 1'b1;

      send32(32'h2001, 2'd0, 32'h0000005A);
      beat32("sb", 32'h2000, 4'b0010, 32'h00005A00, 0);
      resp32("sb", 1'b0, 1'b0);

      // Upper data bits outside the size must not leak onto unstrobed lanes
      send32(32'h3003, 2'd0, 32'h123456A5);
      beat32("sb hi", 32'h3000, 4'b1000, 32'hA5000000, 0);
      resp32("sb hi", 1'b0, 1'b0);

      send32(32'h1002, 2'd2, 32'hAABBCCDD);
      beat32("sw b0", 32'h1000, 4'b1100, 32'hCCDD0000, 0);
      beat32("sw b1", 32'h1004, 4'b0011, 32'h0000AABB, 0);
      resp32("sw split", 1'b0, 1'b1);

      send32(32'h1003, 2'd1, 32'h00001234);
      beat32("sh b0", 32'h1000, 4'b1000, 32'h34000000, 0);
      beat32("sh b1", 32'h1004, 4'b0001, 32'h00000012, 0);
      resp32("sh split", 1'b0, 1'b1);

      send32(32'h1001, 2'd1, 32'h00001234);
      beat32("sh mid", 32'h1000, 4'b0110, 32'h00123400, 0);
      resp32("sh mid", 1'b0, 1'b0);

      send32(32'h4000, 2'd2, 32'hDEADBEEF);
      beat32("sw wait", 32'h4000, 4'b1111, 32'hDEADBEEF, 2);
      resp32("sw wait", 1'b0, 1'b0);

      send32(32'hFFFFFFFE, 2'd2, 32'hAABBCCDD);
      beat32("wrap b0", 32'hFFFFFFFC, 4'b1100, 32'hCCDD0000, 3);
      beat32("wrap b1", 32'h00000000, 4'b0011, 32'h0000AABB, 3);
      resp32("wrap", 1'b0, 1'b1);

      send32(32'h1000, 2'd3, 32'h11111111);
      resp32("sd on 32", 1'b1, 1'b0);

      // Misaligned disallowed: fault one cycle after accept, no bus beat
      @(negedge clk);
      bus32n.req_valid = 1'b1; bus32n.req_addr = 32'h1002; bus32n.req_size = 2'd2;
      bus32n.req_data = 32'hAABBCCDD;
      @(posedge clk);
      @(negedge clk);
      bus32n.req_valid = 1'b0;
      check("nm mis rsp_valid", {63'd0, bus32n.rsp_valid}, 64'd1);
      check("nm mis rsp_fault", {63'd0, bus32n.rsp_fault}, 64'd1);
      check("nm mis mem_valid", {63'd0, bus32n.mem_valid}, 64'd0);
      @(negedge clk);
      bus32n.req_valid = 1'b1; bus32n.req_addr = 32'h1000; bus32n.req_size = 2'd3;
      @(posedge clk);
      @(negedge clk);
      bus32n.req_valid = 1'b0;
      check("nm sd rsp_fault", {63'd0, bus32n.rsp_fault}, 64'd1);
      check("nm sd mem_valid", {63'd0, bus32n.mem_valid}, 64'd0);
      @(negedge clk);
      bus32n.req_valid = 1'b1; bus32n.req_addr = 32'h1004; bus32n.req_size = 2'd2;
      @(posedge clk);
      @(negedge clk);
      bus32n.req_valid = 1'b0;
      check("nm aligned mem_valid", {63'd0, bus32n.mem_valid}, 64'd1);
      check("nm aligned wstrb", {60'd0, bus32n.mem_wstrb}, 64'hF);
      bus32n.mem_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus32n.mem_ready = 1'b0;
      check("nm aligned rsp_valid", {63'd0, bus32n.rsp_valid}, 64'd1);
      check("nm aligned rsp_fault", {63'd0, bus32n.rsp_fault}, 64'd0);

      one64("sd64", 32'h10, 2'd3, 64'h1122334455667788, 32'h10, 8'hFF, 64'h1122334455667788);
      one64("sw64", 32'h14, 2'd2, 64'h00000000AABBCCDD, 32'h10, 8'hF0, 64'hAABBCCDD00000000);

      // Reset during beat1 of a split store
      send32(32'h1002, 2'd2, 32'hAABBCCDD);
      beat32("rst b0", 32'h1000, 4'b1100, 32'hCCDD0000, 0);
      @(negedge clk);
      check("rst b1 mem_valid", {63'd0, bus32.mem_valid}, 64'd1);
      bus32.mem_ready = 1'b0;
      resetn = 1'b0;
      #1;
      check("mid rst mem_valid", {63'd0, bus32.mem_valid}, 64'd0);
      check("mid rst mem_addr", {32'd0, bus32.mem_addr}, 64'd0);
      check("mid rst mem_wdata", {32'd0, bus32.mem_wdata}, 64'd0);
      check("mid rst mem_wstrb", {60'd0, bus32.mem_wstrb}, 64'd0);
      check("mid rst req_ready", {63'd0, bus32.req_ready}, 64'd1);
      check("mid rst rsp_valid", {63'd0, bus32.rsp_valid}, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("post rst rsp_valid", {63'd0, bus32.rsp_valid}, 64'd0);
         check("post rst req_ready", {63'd0, bus32.req_ready}, 64'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
